// File: rtl/mult_div_sequencer.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, HI/LO result registers.
// Latency : done 34 cycles after an accepted start (2 cycles for divide by zero); 35-cycle back-to-back period.
// Backpr. : none; starts while busy are dropped, not queued. Caller watches busy / mult_div_done.
// Ports   : clk, rst (sync, active-high); mult_start/div_start/signed_op/operand_a/operand_b
//           sampled in IDLE; busy, mult_div_done (1-cycle pulse), hi_out, lo_out, div_by_zero.
module mult_div_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mult_start,
  input  logic                  div_start,
  input  logic                  signed_op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  mult_div_done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  div_by_zero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched operand magnitudes and signs
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             is_div_q, is_div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // MULT: {partial product high, multiplier shifting out}; DIV: {remainder, dividend/quotient}
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             dbz_q, dbz_d;

  // Datapath helpers
  logic             start_acc;
  logic             take_mult;
  logic [W-1:0]     a_mag_in;
  logic [W-1:0]     b_mag_in;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_next;
  logic [W:0]       div_shift;
  logic [W:0]       div_trial;
  logic [2*W-1:0]   div_next;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo;
  logic [W-1:0]     rem;
  logic [W-1:0]     hi_fix;
  logic [W-1:0]     lo_fix;
  logic [W-1:0]     a_raw;
  logic             div_zero;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mult_start) begin
          state_d = S_MULT;
        end else if (div_start) begin
          state_d = S_DIV;
        end
      end
      S_MULT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_FIX;
        end
      end
      S_DIV: begin
        // Zero divisor short-circuits straight to DONE on the first DIV cycle
        if (div_zero) begin
          state_d = S_DONE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    busy          = (state_q != S_IDLE);
    mult_div_done = (state_q == S_DONE);
  end

  //--------------------------------------------------------------------------
  // Datapath arithmetic
  //--------------------------------------------------------------------------
  always_comb begin
    start_acc = (state_q == S_IDLE) && (mult_start || div_start);
    take_mult = mult_start;  // multiply wins when both starts are high

    a_mag_in = (signed_op && operand_a[W-1]) ? -operand_a : operand_a;
    b_mag_in = (signed_op && operand_b[W-1]) ? -operand_b : operand_b;

    // Shift-add: add multiplicand to the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right by one (carry included).
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};

    // Restoring divide: shift next dividend bit into the remainder and trial-subtract.
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_trial = div_shift - {1'b0, b_q};
    if (!div_trial[W]) begin
      div_next = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end

    div_zero = (b_q == '0);

    // Sign correction applied in FIX
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo      = acc_q[W-1:0];
    rem      = acc_q[2*W-1:W];
    if (is_div_q) begin
      hi_fix = sign_a_q ? -rem : rem;
      lo_fix = (sign_a_q ^ sign_b_q) ? -quo : quo;
    end else begin
      {hi_fix, lo_fix} = prod_fix;
    end

    // Raw dividend rebuilt from magnitude and sign for the divide-by-zero result
    a_raw = sign_a_q ? -a_q : a_q;
  end

  //--------------------------------------------------------------------------
  // Datapath next-state
  //--------------------------------------------------------------------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          a_d      = a_mag_in;
          b_d      = b_mag_in;
          sign_a_d = signed_op & operand_a[W-1];
          sign_b_d = signed_op & operand_b[W-1];
          is_div_d = !take_mult;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
          acc_d    = take_mult ? {{W{1'b0}}, b_mag_in} : {{W{1'b0}}, a_mag_in};
        end
      end
      S_MULT: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CNT_ONE;
      end
      S_DIV: begin
        if (div_zero) begin
          hi_d  = a_raw;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FIX: begin
        // Results land on the outputs as the FSM enters DONE
        hi_d = hi_fix;
        lo_d = lo_fix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = dbz_q;

endmodule
